md_unit: RTL
============

Name: md_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the rs/rt operands after the EX forwarding muxes, i.e. the values already selected by the forwarding unit's A/B selects.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles into the HI/LO registers, and serves MTHI/MTLO/MFHI/MFLO.
- Drives busy to the hazard unit so dependent HI/LO instructions stall.

Parameters:
- ITERS, 32: iterations per operation, one bit per cycle. Fixed to the 32-bit datapath; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin an operation; driven by EX decode, already qualified by "EX not stalled".
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- opa  input  32  forwarded rs value; sampled with start.
- opb  input  32  forwarded rt value; sampled with start.
- mthi  input  1  write opa into HI.
- mtlo  input  1  write opa into LO.
- flush  input  1  abort the in-flight operation (exception/redirect).
- busy  output  1  operation in progress; hazard unit stalls any HI/LO access while high.
- done  output  1  one-cycle pulse: HI/LO were just updated by a finished operation.
- hi  output  32  HI register, read directly by MFHI.
- lo  output  32  LO register, read directly by MFLO.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0, internal working registers 0. Reset overrides all other inputs, including mid-operation.
- States: IDLE, RUN, FIX.
- IDLE + start (flush low):
  - Latch op, opa, opb; counter=ITERS; go to RUN.
  - busy goes high from the next cycle.
- RUN, one iteration per cycle, counter decrements each cycle:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle on a 33-bit partial remainder.
  - When counter reaches 0, go to FIX.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at start; sign flags are latched.
  - MULT: negate the 64-bit product in FIX if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 magnitudes are handled as unsigned 2^31; no overflow trap.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- FIX (one cycle):
  - Write HI/LO; return to IDLE.
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: hi=remainder, lo=quotient.
- Timing:
  - busy is high exactly ITERS+1 = 33 consecutive cycles, starting the cycle after start is sampled.
  - New hi/lo and done=1 are visible in the first cycle busy is low, i.e. 34 cycles after start is sampled.
  - done is high for exactly one cycle.
- Divide by zero (DIV or DIVU, opb=0): full latency still applies; result hi=opa (original, unsigned view), lo=0xFFFFFFFF.
- mthi/mtlo:
  - Accepted only in IDLE; the register updates at the next edge. Both may be asserted together.
  - Ignored while busy; the hazard unit guarantees they do not occur then.
  - If asserted in the same cycle as start, start wins and the write is dropped.
- start while busy: ignored; the in-flight operation is unaffected.
- flush:
  - In RUN or FIX: abort, hi/lo keep their pre-operation values, busy=0 next cycle, no done pulse.
  - Asserted with start in IDLE: start is ignored.
  - flush with nothing in flight: no effect.
- hi/lo are registered outputs and never show partial results.

Test Plan:
- MULT opa=0xFFFFFFFD (-3), opb=7 → busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse one cycle.
- MULTU opa=opb=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULT same operands → hi=0, lo=1.
- DIV opa=0xFFFFFFF9 (-7), opb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU opa=100, opb=7 → lo=14, hi=2.
- DIVU opa=100, opb=0 → after 33 busy cycles hi=100, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload with mthi/mtlo 0x11111111/0x22222222, start MULT 5*5, assert flush on the 10th busy cycle → busy=0 next cycle, no done, hi/lo still 0x11111111/0x22222222.
- Second start during busy, plus mthi asserted the same cycle as an idle start → first result only, mthi write lost; reset asserted mid-RUN → hi=lo=0, busy=0, done=0 next cycle.

Source files
------------

// File: rtl/md_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with MTHI/MTLO writes while idle.
module md_unit #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_borrow;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Multiply: acc holds {partial sum, multiplier}; divide: acc holds {remainder, dividend/quotient}.
  always_comb begin
    mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_shift  = acc_q[63:31];
    div_borrow = div_shift < {1'b0, b_q};
    div_rem    = 32'(div_shift - {1'b0, b_q});
    prod_fix   = (sa_q ^ sb_q) ? 64'(-acc_q) : acc_q;
    // A zero divisor leaves the dividend magnitude as remainder; re-signing it restores opa.
    quo_fix    = ((sa_q ^ sb_q) && !div0_q) ? 32'(-acc_q[31:0]) : acc_q[31:0];
    rem_fix    = sa_q ? 32'(-acc_q[63:32]) : acc_q[63:32];
    sa_d       = ~op[0] & opa[31];
    sb_d       = ~op[0] & opb[31];
    mag_a      = sa_d ? 32'(-opa) : opa;
    mag_b      = sb_d ? 32'(-opb) : opb;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d  = RUN;
          cnt_d    = 6'(ITERS);
          is_div_d = op[1];
          div0_d   = op[1] && (opb == 32'd0);
          acc_d    = {32'd0, op[1] ? mag_a : mag_b};
          b_d      = op[1] ? mag_b : mag_a;
        end else begin
          if (mthi) hi_d = opa;
          if (mtlo) lo_d = opa;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q)
            acc_d = div_borrow ? {div_shift[31:0], acc_q[30:0], 1'b0}
                               : {div_rem, acc_q[30:0], 1'b1};
          else
            acc_d = {mul_sum, acc_q[31:1]};
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sa_q/sb_q only load on an accepted start so they stay valid through FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      if (state_q == IDLE && start && !flush) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
